l2_dual_channel_scheduler: RTL and testbench
============================================

// Module: l2_dual_channel_scheduler
// PURPOSE
//  Two-channel request scheduler in front of one L2 bank port. It replaces the plain 2:1 request mux after the
//  per-channel arbitration trees. Each channel presents one arbitrated req/gnt stream. The block picks one channel
//  per transaction (fixed priority or round-robin), holds the pick until granted, prevents starvation and caps
//  outstanding reads/writes per channel.
// PARAMETERS
//  ADDR_WIDTH       32   address width
//  DATA_WIDTH       64   write-data width
//  BE_WIDTH         DATA_WIDTH/8  byte-enable width
//  ID_WIDTH         9    transaction ID width
//  MAX_OUTSTANDING  4    max un-responded grants per channel (>=1)
//  STARVE_W         4    width of starvation counter / limit
// PORTS
//  clk                  in   1          clock
//  rst_n                in   1          async active-low reset
//  cfg_rr_mode_i        in   1          0: fixed priority CH0>CH1; 1: round-robin
//  cfg_starve_lim_i     in   STARVE_W   lost-cycles before loser is forced; 0 disables
//  data_req_CHx_i       in   1          request, x in {0,1}
//  data_add_CHx_i       in   ADDR_WIDTH address
//  data_wen_CHx_i       in   1          1=read, 0=write
//  data_wdata_CHx_i     in   DATA_WIDTH write data
//  data_be_CHx_i        in   BE_WIDTH   byte enables
//  data_ID_CHx_i        in   ID_WIDTH   transaction ID
//  data_gnt_CHx_o       out  1          grant back to channel x
//  data_r_valid_CHx_i   in   1          response for channel x (from response decoder)
//  data_req_o/add_o/wen_o/wdata_o/be_o/ID_o  out  as inputs  request to L2 bank
//  data_gnt_i           in   1          bank grant
//  busy_o               out  1          any outstanding count nonzero
// BEHAVIOUR
//  - Clock domain: single clock clk. Reset rst_n is asynchronous and active-low.
//  - Reset: FSM=IDLE, rr_ptr=CH0, starve_cnt=0, out_cnt0/1=0.
//    All outputs are 0 while in reset and no req is present.
//  - Eligibility: elig_x = data_req_CHx_i && (out_cntx < MAX_OUTSTANDING).
//  - Pick in IDLE:
//    - Only one channel eligible: pick that channel.
//    - Both eligible, and cfg_starve_lim_i!=0 and starve_cnt>=cfg_starve_lim_i: pick the non-preferred channel.
//    - Otherwise pick the preferred channel: CH0 when cfg_rr_mode_i=0, rr_ptr when cfg_rr_mode_i=1.
//  - Output path: zero-latency combinational mux of the picked channel's fields.
//    data_req_o = elig_sel. data_gnt_CHx_o = data_gnt_i & data_req_o & (sel==x).
//    Fields of the unselected channel are don't-care; tb checks fields only when data_req_o=1.
//  - FSM IDLE/LOCK0/LOCK1:
//    - IDLE with data_req_o & !data_gnt_i -> LOCKsel. The pick is frozen; fields must stay stable until grant.
//    - IDLE with data_req_o & data_gnt_i -> stay IDLE.
//    - LOCKx on data_gnt_i -> IDLE.
//    - LOCKx when data_req_CHx_i drops (protocol violation) -> IDLE with no grant issued; flagged by assertion.
//    - In LOCKx the other channel never wins, even if the starvation limit is reached.
//  - starve_cnt:
//    - +1 (saturating) each cycle both channels are eligible and the non-preferred one is not granted.
//    - Cleared when the non-preferred channel is granted, or when cfg_rr_mode_i or cfg_starve_lim_i changes.
//  - rr_ptr: toggles to the other channel on every granted transfer (rr mode only). Held in fixed mode.
//  - out_cntx: +1 on data_gnt_CHx_o, -1 on data_r_valid_CHx_i; both in the same cycle -> unchanged.
//    Grant blocked at MAX_OUTSTANDING: elig_x=0 until a response arrives.
//    r_valid while out_cntx==0 is ignored, no underflow, assertion fires.
//  - Reset mid-transaction: all counters are dropped. Responses arriving after reset are ignored per the rule above.
// CONFIGURATION
//  - L2_SCHED_PERF_CNT_EN defined: adds outputs perf_gnt_CH0_o, perf_gnt_CH1_o, perf_stall_o (32 bit each).
//    - perf_gnt_CHx_o counts grants per channel.
//    - perf_stall_o counts cycles with data_req_o & !data_gnt_i.
//    - Cleared by rst_n or by input perf_clr_i (1 bit). Counters wrap at 2^32.
//  - L2_SCHED_PERF_CNT_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  - Fixed mode, lim=0, both req, gnt=1 for 10 cycles -> CH0 gets 10 grants, CH1 gets 0.
//  - Fixed mode, lim=3, both req, gnt=1 -> grant pattern CH0,CH0,CH0,CH1 repeating; starve_cnt clears after each CH1 grant.
//  - RR mode, both req, gnt=1 -> strict alternation CH0,CH1,CH0... starting at CH0 after reset.
//  - CH1 req, gnt=0 for 3 cycles, CH0 req raised in cycle 2 -> data_req_o stays on CH1 with stable fields;
//    CH1 granted in cycle 4; CH0 served next.
//  - MAX_OUTSTANDING=4, CH0 only, gnt=1, no r_valid -> 4 grants, then data_req_o=0.
//    One r_valid_CH0 -> exactly one more grant.
//    Same-cycle gnt+r_valid -> out_cnt0 unchanged.
//  - rst_n asserted while in LOCK1 with out_cnt1=2 -> next cycle IDLE, busy_o=0, all grants 0.
//    With PERF_CNT_EN: counters read 0.

Source files
------------

// File: rtl/l2_dual_channel_scheduler.sv
// l2_dual_channel_scheduler: two-channel L2 request scheduler with lock-until-grant, anti-starvation and per-channel outstanding caps.
// Define L2_SCHED_PERF_CNT_EN to add grant/stall performance counters.
module l2_dual_channel_scheduler #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 64,
    parameter int BE_WIDTH        = DATA_WIDTH/8,
    parameter int ID_WIDTH        = 9,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_W        = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_rr_mode_i,
    input  logic [STARVE_W-1:0]   cfg_starve_lim_i,
    input  logic                  data_req_CH0_i,
    input  logic [ADDR_WIDTH-1:0] data_add_CH0_i,
    input  logic                  data_wen_CH0_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_CH0_i,
    input  logic [BE_WIDTH-1:0]   data_be_CH0_i,
    input  logic [ID_WIDTH-1:0]   data_ID_CH0_i,
    output logic                  data_gnt_CH0_o,
    input  logic                  data_r_valid_CH0_i,
    input  logic                  data_req_CH1_i,
    input  logic [ADDR_WIDTH-1:0] data_add_CH1_i,
    input  logic                  data_wen_CH1_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_CH1_i,
    input  logic [BE_WIDTH-1:0]   data_be_CH1_i,
    input  logic [ID_WIDTH-1:0]   data_ID_CH1_i,
    output logic                  data_gnt_CH1_o,
    input  logic                  data_r_valid_CH1_i,
    output logic                  data_req_o,
    output logic [ADDR_WIDTH-1:0] data_add_o,
    output logic                  data_wen_o,
    output logic [DATA_WIDTH-1:0] data_wdata_o,
    output logic [BE_WIDTH-1:0]   data_be_o,
    output logic [ID_WIDTH-1:0]   data_ID_o,
    input  logic                  data_gnt_i,
    output logic                  busy_o
`ifdef L2_SCHED_PERF_CNT_EN
    ,
    input  logic                  perf_clr_i,
    output logic [31:0]           perf_gnt_CH0_o,
    output logic [31:0]           perf_gnt_CH1_o,
    output logic [31:0]           perf_stall_o
`endif
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t              r_state, w_state_nxt;
    logic                r_rr_ptr, r_prev_rr;
    logic [STARVE_W-1:0] r_starve, r_prev_lim, w_starve_nxt;
    logic [CW-1:0]       r_cnt0, r_cnt1;
    logic                w_elig0, w_elig1, w_pref, w_force, w_sel, w_gnt;
    logic                w_dec0, w_dec1, w_cfg_chg, w_np_gnt;

    always_comb begin
        w_elig0      = data_req_CH0_i && (r_cnt0 < MAXC);
        w_elig1      = data_req_CH1_i && (r_cnt1 < MAXC);
        w_pref       = cfg_rr_mode_i & r_rr_ptr;
        w_force      = (cfg_starve_lim_i != '0) && (r_starve >= cfg_starve_lim_i);
        // a locked pick is never overridden, not even by the starvation limit
        w_sel        = (r_state == LOCK1) ? 1'b1 :
                       (r_state == LOCK0) ? 1'b0 :
                       (w_elig0 && w_elig1) ? (w_force ? ~w_pref : w_pref) : w_elig1;
        data_req_o   = w_sel ? w_elig1 : w_elig0;
        w_gnt        = data_req_o & data_gnt_i;
        data_gnt_CH0_o = w_gnt & ~w_sel;
        data_gnt_CH1_o = w_gnt & w_sel;
        data_add_o   = data_req_o ? (w_sel ? data_add_CH1_i   : data_add_CH0_i)   : '0;
        data_wen_o   = data_req_o ? (w_sel ? data_wen_CH1_i   : data_wen_CH0_i)   : 1'b0;
        data_wdata_o = data_req_o ? (w_sel ? data_wdata_CH1_i : data_wdata_CH0_i) : '0;
        data_be_o    = data_req_o ? (w_sel ? data_be_CH1_i    : data_be_CH0_i)    : '0;
        data_ID_o    = data_req_o ? (w_sel ? data_ID_CH1_i    : data_ID_CH0_i)    : '0;
        // a dropped request while locked lands in IDLE because data_req_o falls
        w_state_nxt  = (data_req_o && !data_gnt_i) ? (w_sel ? LOCK1 : LOCK0) : IDLE;
        w_dec0       = data_r_valid_CH0_i && (r_cnt0 != '0);
        w_dec1       = data_r_valid_CH1_i && (r_cnt1 != '0);
        w_cfg_chg    = (cfg_rr_mode_i != r_prev_rr) || (cfg_starve_lim_i != r_prev_lim);
        w_np_gnt     = w_gnt && (w_sel != w_pref);
        w_starve_nxt = (w_cfg_chg || w_np_gnt) ? '0 :
                       (w_elig0 && w_elig1 && (r_starve != '1)) ? r_starve + 1'b1 : r_starve;
        busy_o       = (r_cnt0 != '0) || (r_cnt1 != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_rr_ptr   <= 1'b0;
            r_prev_rr  <= 1'b0;
            r_prev_lim <= '0;
            r_starve   <= '0;
            r_cnt0     <= '0;
            r_cnt1     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_prev_rr  <= cfg_rr_mode_i;
            r_prev_lim <= cfg_starve_lim_i;
            r_starve   <= w_starve_nxt;
            if (cfg_rr_mode_i && w_gnt)
                r_rr_ptr <= ~w_sel;
            r_cnt0 <= (data_gnt_CH0_o && !w_dec0) ? r_cnt0 + 1'b1 :
                      (!data_gnt_CH0_o && w_dec0) ? r_cnt0 - 1'b1 : r_cnt0;
            r_cnt1 <= (data_gnt_CH1_o && !w_dec1) ? r_cnt1 + 1'b1 :
                      (!data_gnt_CH1_o && w_dec1) ? r_cnt1 - 1'b1 : r_cnt1;
        end
    end

`ifdef L2_SCHED_PERF_CNT_EN
    logic [31:0] r_perf_gnt0, r_perf_gnt1, r_perf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_gnt0  <= '0;
            r_perf_gnt1  <= '0;
            r_perf_stall <= '0;
        end else if (perf_clr_i) begin
            r_perf_gnt0  <= '0;
            r_perf_gnt1  <= '0;
            r_perf_stall <= '0;
        end else begin
            r_perf_gnt0  <= r_perf_gnt0 + 32'(data_gnt_CH0_o);
            r_perf_gnt1  <= r_perf_gnt1 + 32'(data_gnt_CH1_o);
            r_perf_stall <= r_perf_stall + 32'(data_req_o & ~data_gnt_i);
        end
    end

    assign perf_gnt_CH0_o = r_perf_gnt0;
    assign perf_gnt_CH1_o = r_perf_gnt1;
    assign perf_stall_o   = r_perf_stall;
`endif

`ifndef SYNTHESIS
    a_lock0_req: assert property (@(posedge clk) disable iff (!rst_n) (r_state == LOCK0) |-> data_req_CH0_i);
    a_lock1_req: assert property (@(posedge clk) disable iff (!rst_n) (r_state == LOCK1) |-> data_req_CH1_i);
    a_rsp0_cnt:  assert property (@(posedge clk) disable iff (!rst_n) data_r_valid_CH0_i |-> (r_cnt0 != '0));
    a_rsp1_cnt:  assert property (@(posedge clk) disable iff (!rst_n) data_r_valid_CH1_i |-> (r_cnt1 != '0));
`endif
endmodule

// File: tb/tb_l2_dual_channel_scheduler.sv
// tb_l2_dual_channel_scheduler: table-driven checks of pick, lock, starvation and round-robin, plus hand-written outstanding-cap and reset sequences.
module tb_l2_dual_channel_scheduler;
    localparam logic [31:0] A0 = 32'h1000_0040, A1 = 32'h2000_0080;
    localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF, D1 = 64'hFEDC_BA98_7654_3210;
    localparam logic [8:0]  I0 = 9'h0A5, I1 = 9'h15A;

    logic        clk, rst_n, rr, req0, req1, rv0, rv1, gnt;
    logic [3:0]  lim;
    logic        gnt0, gnt1, req_o, wen_o, busy;
    logic [31:0] add_o;
    logic [63:0] wdata_o;
    logic [7:0]  be_o;
    logic [8:0]  id_o;
`ifdef L2_SCHED_PERF_CNT_EN
    logic        perf_clr;
    logic [31:0] perf_g0, perf_g1, perf_st;
`endif

    int n_tests = 0, n_fail = 0;

    l2_dual_channel_scheduler dut (
        .clk(clk), .rst_n(rst_n), .cfg_rr_mode_i(rr), .cfg_starve_lim_i(lim),
        .data_req_CH0_i(req0), .data_add_CH0_i(A0), .data_wen_CH0_i(1'b1), .data_wdata_CH0_i(D0),
        .data_be_CH0_i(8'hFF), .data_ID_CH0_i(I0), .data_gnt_CH0_o(gnt0), .data_r_valid_CH0_i(rv0),
        .data_req_CH1_i(req1), .data_add_CH1_i(A1), .data_wen_CH1_i(1'b0), .data_wdata_CH1_i(D1),
        .data_be_CH1_i(8'h0F), .data_ID_CH1_i(I1), .data_gnt_CH1_o(gnt1), .data_r_valid_CH1_i(rv1),
        .data_req_o(req_o), .data_add_o(add_o), .data_wen_o(wen_o), .data_wdata_o(wdata_o),
        .data_be_o(be_o), .data_ID_o(id_o), .data_gnt_i(gnt), .busy_o(busy)
`ifdef L2_SCHED_PERF_CNT_EN
        , .perf_clr_i(perf_clr), .perf_gnt_CH0_o(perf_g0), .perf_gnt_CH1_o(perf_g1), .perf_stall_o(perf_st)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       r0, r1, g, v0, v1, rr;
        bit [3:0] lim;
        bit       eq, es, eg0, eg1, ebusy;
    } vec_t;

    vec_t vq[$];
    bit   pg0 = 1'b0, pg1 = 1'b0;

    // Responses come back one cycle after each expected grant, so the outstanding count is just last cycle's grant.
    function automatic void push(bit r0, bit r1, bit g, bit m, bit [3:0] l, bit eq, bit es);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.g = g; v.rr = m; v.lim = l; v.eq = eq; v.es = es;
        v.v0 = pg0; v.v1 = pg1; v.ebusy = pg0 | pg1;
        v.eg0 = g & eq & ~es;
        v.eg1 = g & eq & es;
        pg0 = v.eg0; pg1 = v.eg1;
        vq.push_back(v);
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic drive(input bit r0, input bit r1, input bit g, input bit v0, input bit v1);
        req0 = r0; req1 = r1; gnt = g; rv0 = v0; rv1 = v1;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; rr = 1'b0; lim = 4'd0;
`ifdef L2_SCHED_PERF_CNT_EN
        perf_clr = 1'b0;
`endif
        drive(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", req_o, 0);
        chk("rst_gnt", {gnt0, gnt1}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_add", add_o, 0);
        rst_n = 1'b1;

        push(0, 0, 0, 0, 0, 0, 0);
        repeat (10) push(1, 1, 1, 0, 0, 1, 0);
        push(0, 0, 0, 0, 3, 0, 0);
        repeat (2) begin
            repeat (3) push(1, 1, 1, 0, 3, 1, 0);
            push(1, 1, 1, 0, 3, 1, 1);
        end
        push(0, 0, 0, 1, 0, 0, 0);
        repeat (3) begin
            push(1, 1, 1, 1, 0, 1, 0);
            push(1, 1, 1, 1, 0, 1, 1);
        end
        push(0, 0, 0, 0, 0, 0, 0);
        repeat (2) push(0, 1, 1, 0, 0, 1, 1);
        push(0, 1, 0, 0, 0, 1, 1);
        push(1, 1, 0, 0, 0, 1, 1);
        push(1, 1, 0, 0, 0, 1, 1);
        push(1, 1, 1, 0, 0, 1, 1);
        push(1, 0, 1, 0, 0, 1, 0);
        push(0, 0, 0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 0, 0);

        foreach (vq[i]) begin
            rr = vq[i].rr; lim = vq[i].lim;
            drive(vq[i].r0, vq[i].r1, vq[i].g, vq[i].v0, vq[i].v1);
            chk($sformatf("vec%0d_req", i), req_o, vq[i].eq);
            chk($sformatf("vec%0d_gnt", i), {gnt0, gnt1}, {vq[i].eg0, vq[i].eg1});
            chk($sformatf("vec%0d_busy", i), busy, vq[i].ebusy);
            if (vq[i].eq) begin
                chk($sformatf("vec%0d_add", i), add_o, vq[i].es ? A1 : A0);
                chk($sformatf("vec%0d_id", i), id_o, vq[i].es ? I1 : I0);
                chk($sformatf("vec%0d_wdata", i), wdata_o, vq[i].es ? D1 : D0);
                chk($sformatf("vec%0d_wen", i), wen_o, !vq[i].es);
            end
            tick();
        end

        rr = 1'b0; lim = 4'd0;
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 1, 0, 0); chk($sformatf("cap_gnt%0d", k), gnt0, 1); tick();
        end
        drive(1, 0, 1, 0, 0); chk("cap_block", req_o, 0); chk("cap_busy", busy, 1); tick();
        drive(1, 0, 1, 1, 0); chk("cap_rsp_cycle", req_o, 0); tick();
        drive(1, 0, 1, 0, 0); chk("cap_one_more", gnt0, 1); tick();
        drive(1, 0, 1, 1, 0); chk("cap_block2", req_o, 0); tick();
        drive(1, 0, 1, 1, 0); chk("same_cyc_gnt", gnt0, 1); tick();
        drive(1, 0, 1, 0, 0); chk("after_same_cyc", gnt0, 1); tick();
        drive(1, 0, 1, 0, 0); chk("cap_block3", req_o, 0); tick();

        drive(0, 1, 1, 0, 0); chk("ch1_gnt_a", gnt1, 1); tick();
        drive(0, 1, 1, 0, 0); chk("ch1_gnt_b", gnt1, 1); tick();
        drive(0, 1, 0, 0, 0); chk("lock1_req", req_o, 1); chk("lock1_nogrant", gnt1, 0); tick();
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", {gnt0, gnt1}, 0);
        chk("mid_rst_busy", busy, 0);
`ifdef L2_SCHED_PERF_CNT_EN
        chk("perf_rst", {perf_g0, perf_g1, perf_st}, 0);
`endif
        drive(0, 0, 0, 0, 0); chk("mid_rst_req", req_o, 0);
        tick();
        rst_n = 1'b1;
        drive(1, 0, 1, 0, 0); chk("post_rst_ch0", gnt0, 1); tick();
        drive(0, 0, 0, 0, 0); chk("post_rst_busy", busy, 1);
`ifdef L2_SCHED_PERF_CNT_EN
        chk("perf_gnt0", perf_g0, 1);
`endif
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
